// File: rtl/cntr_pkg.sv
// ============================================================================
// Module      : cntr_pkg
// Description : Shared constants and helpers for the parametrised up/down
//               counter (mode and direction encodings, terminal value).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cntr_pkg;

   // Boundary behaviour selected by the SAT_MODE parameter
   localparam int CNTR_WRAP = 0;
   localparam int CNTR_SAT  = 1;

   // Encoding of the up_dn input
   localparam logic CNTR_UP   = 1'b1;
   localparam logic CNTR_DOWN = 1'b0;

   // Highest legal count (MODULO-1), masked to the counter width so the
   // caller can narrow it to WIDTH bits without losing information.
   function automatic logic [31:0] cntr_max(input int unsigned modulo,
                                            input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (modulo - 32'd1) & mask;
   endfunction

endpackage : cntr_pkg

`default_nettype wire

// File: rtl/cntr_next_val.sv
// ============================================================================
// Module      : cntr_next_val
// Description : Combinational next-state logic of the up/down counter:
//               clear/load/count priority, load clamping, wrap/saturate
//               at the MODULO boundaries and the wrap-event flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr_next_val
   import cntr_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MODULO   = 256,
   parameter int SAT_MODE = CNTR_WRAP
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up_dn,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q_next,
   output logic             wrap_next
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(cntr_max(MODULO, WIDTH));
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   // Next count with priority clr > load > en; holds when none asserted
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (clr) begin
         q_next = '0;
      end else if (load) begin
         // Out-of-range load values are clamped to the top of the range
         q_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (en) begin
         if (up_dn == CNTR_UP) begin
            if (q == MAX_VAL) begin
               if (SAT_MODE != CNTR_SAT) begin
                  q_next    = '0;
                  wrap_next = 1'b1;
               end
            end else begin
               q_next = q + ONE;
            end
         end else begin
            if (q == '0) begin
               if (SAT_MODE != CNTR_SAT) begin
                  q_next    = MAX_VAL;
                  wrap_next = 1'b1;
               end
            end else begin
               q_next = q - ONE;
            end
         end
      end
   end

endmodule : cntr_next_val

`default_nettype wire

// File: rtl/cntr_nbit_updown.sv
// ============================================================================
// Module      : cntr_nbit_updown
// Description : Parametrised modulo-N up/down counter with enable, sync
//               clear, parallel load (clamped), wrap or saturate mode,
//               combinational terminal count and registered wrap pulse.
//               Optional compare output enabled by defining CNTR_CMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr_nbit_updown
   import cntr_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MODULO   = 256,
   parameter int SAT_MODE = CNTR_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef CNTR_CMP_EN
   input  logic [WIDTH-1:0] cmp_val,
   output logic             cmp_hit,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(cntr_max(MODULO, WIDTH));

   // Reject illegal parameter combinations at elaboration time
   generate
      if ((MODULO < 2) || (longint'(MODULO) > (longint'(1) << WIDTH)) ||
          ((SAT_MODE != CNTR_WRAP) && (SAT_MODE != CNTR_SAT))) begin : g_param_check
         $error("cntr_nbit_updown: need 2 <= MODULO <= 2**WIDTH and SAT_MODE in {0,1}");
      end
   endgenerate

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   cntr_next_val #(
      .WIDTH    (WIDTH),
      .MODULO   (MODULO),
      .SAT_MODE (SAT_MODE)
   ) u_next_val (
      .q         (q),
      .up_dn     (up_dn),
      .en        (en),
      .clr       (clr),
      .load      (load),
      .load_val  (load_val),
      .q_next    (q_next),
      .wrap_next (wrap_next)
   );

   // Count and wrap-pulse registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

   // Terminal count looks at the current direction, not the enable
   assign tc = (up_dn == CNTR_DOWN) ? (q == '0) : (q == MAX_VAL);

`ifdef CNTR_CMP_EN
   // Flag lands together with the matching count; out-of-range never hits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmp_hit <= 1'b0;
      end else begin
         cmp_hit <= (cmp_val <= MAX_VAL) && (q_next == cmp_val);
      end
   end
`endif

endmodule : cntr_nbit_updown

`default_nettype wire
